// File: rtl/region_mover_pkg.sv
// Shared constants, direction bit indices and FSM state type for region_mover.
// Default display geometry matches a 640x480 VGA timing.
package region_mover_pkg;

    localparam int H_DISP_DEF = 640;
    localparam int V_DISP_DEF = 480;
    localparam int H_SIZE_DEF = 256;
    localparam int V_SIZE_DEF = 128;
    localparam int H_UNIT_DEF = 8;
    localparam int V_UNIT_DEF = 16;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_STEP,
        ST_DONE
    } state_t;

    // Opposing requests on one axis cancel each other out.
    function automatic logic [3:0] resolve_dirs(input logic [3:0] p);
        logic [3:0] r;
        r = p;
        if (p[DIR_LEFT] && p[DIR_RIGHT]) begin
            r[DIR_LEFT]  = 1'b0;
            r[DIR_RIGHT] = 1'b0;
        end
        if (p[DIR_UP] && p[DIR_DOWN]) begin
            r[DIR_UP]   = 1'b0;
            r[DIR_DOWN] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/region_mover_axis_stepper.sv
// One-axis, one-unit position step with wrap-around, or saturation when
// REGION_MOVER_CLAMP_EN is defined. End is always re-derived from the new Start.
module axis_stepper
    import region_mover_pkg::*;
#(
    parameter int DISP = H_DISP_DEF,
    parameter int SIZE = H_SIZE_DEF,
    parameter int UNIT = H_UNIT_DEF,
    parameter int W    = $clog2(DISP)
) (
    input  logic [W-1:0] start,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] start_next,
    output logic [W-1:0] end_next
);

    // One extra bit keeps S + UNIT and S + SIZE - 1 from overflowing.
    localparam int W1 = W + 1;
    localparam logic [W:0] DISP_C    = W1'(DISP);
    localparam logic [W:0] UNIT_C    = W1'(UNIT);
    localparam logic [W:0] SIZE_M1   = W1'(SIZE - 1);
    localparam logic [W:0] MAX_START = W1'(DISP - SIZE);

    logic [W:0] s_ext;
    logic [W:0] s_new;
    logic [W:0] e_new;

    always_comb begin
        s_ext = {1'b0, start};
        s_new = s_ext;
`ifdef REGION_MOVER_CLAMP_EN
        if (inc) begin
            s_new = (s_ext + UNIT_C > MAX_START) ? MAX_START : s_ext + UNIT_C;
        end else if (dec) begin
            s_new = (s_ext < UNIT_C) ? '0 : s_ext - UNIT_C;
        end
`else
        if (inc) begin
            s_new = s_ext + UNIT_C;
            if (s_new >= DISP_C) begin
                s_new = s_new - DISP_C;
            end
        end else if (dec) begin
            s_new = (s_ext < UNIT_C) ? s_ext + DISP_C - UNIT_C : s_ext - UNIT_C;
        end
`endif
        e_new = s_new + SIZE_M1;
        if (e_new >= DISP_C) begin
            e_new = e_new - DISP_C;
        end
        start_next = s_new[W-1:0];
        end_next   = e_new[W-1:0];
    end

endmodule

// File: rtl/region_mover.sv
// Drawable-region mover: edge-detected direction requests are applied at the next
// frame boundary, one unit per clock. Define REGION_MOVER_CLAMP_EN to saturate at edges.
module region_mover
    import region_mover_pkg::*;
#(
    parameter int H_DISP = H_DISP_DEF,
    parameter int V_DISP = V_DISP_DEF,
    parameter int H_SIZE = H_SIZE_DEF,
    parameter int V_SIZE = V_SIZE_DEF,
    parameter int H_UNIT = H_UNIT_DEF,
    parameter int V_UNIT = V_UNIT_DEF,
    localparam int HW = $clog2(H_DISP),
    localparam int VW = $clog2(V_DISP)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    offsetFlag,
    input  logic [3:0]    offsetStep,
    input  logic          frameTick,
    output logic [HW-1:0] posHorStart,
    output logic [HW-1:0] posHorEnd,
    output logic [VW-1:0] posVerStart,
    output logic [VW-1:0] posVerEnd,
    output logic          wrapH,
    output logic          wrapV,
    output logic          busy,
    output logic          moveDone
);

    localparam int H_START_I = (H_DISP - H_SIZE) / 2;
    localparam int V_START_I = (V_DISP - V_SIZE) / 2;
    localparam logic [HW-1:0] H_START_RST = HW'(H_START_I);
    localparam logic [HW-1:0] H_END_RST   = HW'(H_START_I + H_SIZE - 1);
    localparam logic [VW-1:0] V_START_RST = VW'(V_START_I);
    localparam logic [VW-1:0] V_END_RST   = VW'(V_START_I + V_SIZE - 1);

    state_t state_reg, state_next;

    logic [3:0] flag_reg;
    logic [3:0] flag_prev_reg;
    logic [3:0] rise;
    logic [3:0] pending_reg, pending_next;
    logic [3:0] dir_reg, dir_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       consume;
    logic       step_en;

    logic [HW-1:0] h_start_reg, h_end_reg, h_start_next, h_end_next;
    logic [VW-1:0] v_start_reg, v_end_reg, v_start_next, v_end_next;
    logic          wrap_h_reg, wrap_v_reg;
    logic          busy_reg;
    logic          move_done_reg;

    for (genvar gi = 0; gi < 4; gi++) begin : g_edge
        assign rise[gi] = flag_reg[gi] & ~flag_prev_reg[gi];
    end

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        cnt_next   = cnt_reg;
        consume    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pending_reg != 4'd0) begin
                    state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                if (frameTick) begin
                    consume = 1'b1;
                    if (pending_reg == 4'd0 || offsetStep == 4'd0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_STEP;
                        dir_next   = pending_reg;
                        cnt_next   = offsetStep;
                    end
                end else if (pending_reg == 4'd0) begin
                    // A late opposing request cancelled everything queued.
                    state_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = (pending_reg != 4'd0) ? ST_PEND : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        pending_next = resolve_dirs((consume ? 4'd0 : pending_reg) | rise);
    end

    assign step_en = (state_reg == ST_STEP);

    axis_stepper #(
        .DISP(H_DISP), .SIZE(H_SIZE), .UNIT(H_UNIT), .W(HW)
    ) u_step_h (
        .start      (h_start_reg),
        .inc        (step_en & dir_reg[DIR_RIGHT]),
        .dec        (step_en & dir_reg[DIR_LEFT]),
        .start_next (h_start_next),
        .end_next   (h_end_next)
    );

    axis_stepper #(
        .DISP(V_DISP), .SIZE(V_SIZE), .UNIT(V_UNIT), .W(VW)
    ) u_step_v (
        .start      (v_start_reg),
        .inc        (step_en & dir_reg[DIR_DOWN]),
        .dec        (step_en & dir_reg[DIR_UP]),
        .start_next (v_start_next),
        .end_next   (v_end_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            flag_reg      <= '0;
            flag_prev_reg <= '0;
            pending_reg   <= '0;
            dir_reg       <= '0;
            cnt_reg       <= '0;
            h_start_reg   <= H_START_RST;
            h_end_reg     <= H_END_RST;
            v_start_reg   <= V_START_RST;
            v_end_reg     <= V_END_RST;
            wrap_h_reg    <= 1'b0;
            wrap_v_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            move_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flag_reg      <= offsetFlag;
            flag_prev_reg <= flag_reg;
            pending_reg   <= pending_next;
            dir_reg       <= dir_next;
            cnt_reg       <= cnt_next;
            busy_reg      <= (state_next == ST_PEND) || (state_next == ST_STEP);
            move_done_reg <= (state_reg == ST_DONE);
            if (step_en) begin
                h_start_reg <= h_start_next;
                h_end_reg   <= h_end_next;
                v_start_reg <= v_start_next;
                v_end_reg   <= v_end_next;
`ifdef REGION_MOVER_CLAMP_EN
                wrap_h_reg  <= 1'b0;
                wrap_v_reg  <= 1'b0;
`else
                wrap_h_reg  <= (h_end_next < h_start_next);
                wrap_v_reg  <= (v_end_next < v_start_next);
`endif
            end
        end
    end

    assign posHorStart = h_start_reg;
    assign posHorEnd   = h_end_reg;
    assign posVerStart = v_start_reg;
    assign posVerEnd   = v_end_reg;
    assign wrapH       = wrap_h_reg;
    assign wrapV       = wrap_v_reg;
    assign busy        = busy_reg;
    assign moveDone    = move_done_reg;

endmodule

// File: tb/tb_region_mover.sv
// Directed bench for region_mover with default parameters; expectations follow
// REGION_MOVER_CLAMP_EN when it is defined.
module tb_region_mover;

    localparam logic [3:0] UP    = 4'b0001;
    localparam logic [3:0] DOWN  = 4'b0010;
    localparam logic [3:0] LEFT  = 4'b0100;
    localparam logic [3:0] RIGHT = 4'b1000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] offsetFlag;
    logic [3:0] offsetStep;
    logic       frameTick;
    logic [9:0] posHorStart, posHorEnd;
    logic [8:0] posVerStart, posVerEnd;
    logic       wrapH, wrapV, busy, moveDone;

    int checks = 0;
    int errors = 0;

    region_mover dut (
        .clk         (clk),
        .reset       (reset),
        .offsetFlag  (offsetFlag),
        .offsetStep  (offsetStep),
        .frameTick   (frameTick),
        .posHorStart (posHorStart),
        .posHorEnd   (posHorEnd),
        .posVerStart (posVerStart),
        .posVerEnd   (posVerEnd),
        .wrapH       (wrapH),
        .wrapV       (wrapV),
        .busy        (busy),
        .moveDone    (moveDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] flag;
        logic [3:0] step;
        bit         from_reset;
        int         hs, he, vs, ve;
        int         wh, wv;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_pos(input string name, input int hs, input int he,
                             input int vs, input int ve);
        check({name, " hs"}, int'(posHorStart), hs);
        check({name, " he"}, int'(posHorEnd), he);
        check({name, " vs"}, int'(posVerStart), vs);
        check({name, " ve"}, int'(posVerEnd), ve);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Raise the flags long enough to reach PEND, then issue one frame tick.
    task automatic request(input logic [3:0] f, input logic [3:0] s);
        offsetFlag = f;
        offsetStep = s;
        repeat (4) tick();
        offsetFlag = 4'd0;
        frameTick  = 1'b1;
        tick();
        frameTick  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int found;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            tick();
            if (moveDone) found = 1;
        end
        check({name, " moveDone seen"}, found, 1);
    endtask

    initial begin
        int hi_cnt;
        reset      = 1'b1;
        offsetFlag = 4'd0;
        offsetStep = 4'd0;
        frameTick  = 1'b0;

        //           flag        step   rst  hs   he   vs   ve  wh wv
        vecs[0]  = '{RIGHT,       4'd1,  1, 200, 455, 176, 303, 0, 0};
        vecs[1]  = '{LEFT,        4'd3,  1, 168, 423, 176, 303, 0, 0};
        vecs[2]  = '{DOWN,        4'd2,  1, 192, 447, 208, 335, 0, 0};
        vecs[4]  = '{RIGHT,       4'd15, 1, 312, 567, 176, 303, 0, 0};
        vecs[6]  = '{LEFT,        4'd15, 1,  72, 327, 176, 303, 0, 0};
        vecs[9]  = '{RIGHT|DOWN,  4'd4,  1, 224, 479, 240, 367, 0, 0};
        vecs[10] = '{UP|LEFT,     4'd2,  1, 176, 431, 144, 271, 0, 0};
`ifdef REGION_MOVER_CLAMP_EN
        vecs[3]  = '{UP,          4'd12, 1, 192, 447,   0, 127, 0, 0};
        vecs[5]  = '{RIGHT,       4'd15, 0, 384, 639, 176, 303, 0, 0};
        vecs[7]  = '{LEFT,        4'd15, 0,   0, 255, 176, 303, 0, 0};
        vecs[8]  = '{DOWN,        4'd15, 1, 192, 447, 352, 479, 0, 0};
`else
        vecs[3]  = '{UP,          4'd12, 1, 192, 447, 464, 111, 0, 1};
        vecs[5]  = '{RIGHT,       4'd15, 0, 432,  47, 176, 303, 1, 0};
        vecs[7]  = '{LEFT,        4'd15, 0, 592, 207, 176, 303, 1, 0};
        vecs[8]  = '{DOWN,        4'd15, 1, 192, 447, 416,  63, 0, 1};
`endif

        // Reset state
        do_reset();
        check_pos("reset", 192, 447, 176, 303);
        check("reset busy", int'(busy), 0);
        check("reset wrapH", int'(wrapH), 0);
        check("reset wrapV", int'(wrapV), 0);
        check("reset moveDone", int'(moveDone), 0);

        // Table of single moves
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].from_reset) do_reset();
            request(vecs[i].flag, vecs[i].step);
            wait_done($sformatf("vec%0d", i));
            check_pos($sformatf("vec%0d", i), vecs[i].hs, vecs[i].he, vecs[i].vs, vecs[i].ve);
            check($sformatf("vec%0d wrapH", i), int'(wrapH), vecs[i].wh);
            check($sformatf("vec%0d wrapV", i), int'(wrapV), vecs[i].wv);
            tick();
            check($sformatf("vec%0d busy", i), int'(busy), 0);
            check($sformatf("vec%0d pulse width", i), int'(moveDone), 0);
            $display("vec %0d: flag=%b step=%0d -> H %0d/%0d V %0d/%0d wrap %0b%0b",
                     i, vecs[i].flag, vecs[i].step, posHorStart, posHorEnd,
                     posVerStart, posVerEnd, wrapH, wrapV);
        end

        // Exact latency of a one-unit Right move
        do_reset();
        offsetFlag = RIGHT;
        offsetStep = 4'd1;
        repeat (4) tick();
        check("lat busy in PEND", int'(busy), 1);
        offsetFlag = 4'd0;
        frameTick  = 1'b1;
        tick();
        frameTick  = 1'b0;
        check("lat hold at STEP entry", int'(posHorStart), 192);
        tick();
        check("lat hs", int'(posHorStart), 200);
        check("lat he", int'(posHorEnd), 455);
        check("lat moveDone early", int'(moveDone), 0);
        tick();
        check("lat moveDone", int'(moveDone), 1);
        check("lat busy after", int'(busy), 0);
        tick();
        check("lat moveDone one cycle", int'(moveDone), 0);
        $display("seq latency: H %0d/%0d", posHorStart, posHorEnd);

        // Left and Right in the same cycle cancel
        do_reset();
        offsetFlag = LEFT | RIGHT;
        offsetStep = 4'd3;
        repeat (4) tick();
        offsetFlag = 4'd0;
        frameTick  = 1'b1;
        tick();
        frameTick  = 1'b0;
        hi_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (busy || moveDone) hi_cnt++;
            tick();
        end
        check("cancel busy/moveDone cycles", hi_cnt, 0);
        check_pos("cancel", 192, 447, 176, 303);
        $display("seq cancel: H %0d/%0d", posHorStart, posHorEnd);

        // Down raised during a 5-unit Right move waits for the next frame tick
        do_reset();
        offsetFlag = RIGHT;
        offsetStep = 4'd5;
        repeat (4) tick();
        offsetFlag = DOWN;
        frameTick  = 1'b1;
        tick();
        frameTick  = 1'b0;
        wait_done("defer");
        check_pos("defer move1", 232, 487, 176, 303);
        repeat (3) tick();
        check("defer busy pending", int'(busy), 1);
        check("defer vs held", int'(posVerStart), 176);
        offsetFlag = 4'd0;
        offsetStep = 4'd1;
        frameTick  = 1'b1;
        tick();
        frameTick  = 1'b0;
        tick();
        check_pos("defer move2", 232, 487, 192, 319);
        $display("seq defer: H %0d/%0d V %0d/%0d", posHorStart, posHorEnd, posVerStart, posVerEnd);

        // Reset in the third STEP cycle abandons the move and queued request
        do_reset();
        offsetFlag = RIGHT | DOWN;
        offsetStep = 4'd5;
        repeat (4) tick();
        offsetFlag = UP;
        frameTick  = 1'b1;
        tick();
        frameTick  = 1'b0;
        tick();
        tick();
        check("midreset progress hs", int'(posHorStart), 208);
        reset      = 1'b1;
        offsetFlag = 4'd0;
        tick();
        reset = 1'b0;
        check_pos("midreset", 192, 447, 176, 303);
        check("midreset busy", int'(busy), 0);
        repeat (4) tick();
        check("midreset pending cleared", int'(busy), 0);
        check("midreset hs stays", int'(posHorStart), 192);
        $display("seq midreset: H %0d/%0d V %0d/%0d", posHorStart, posHorEnd, posVerStart, posVerEnd);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/region_mover.md
# region_mover

Parametrised, clocked successor to the drawable-region offset logic in the VGA controller. Direction requests are edge-detected, held until the next frame boundary, then applied as `offsetStep` unit moves, one unit per clock. Horizontal and vertical positions either wrap around the display edges or clamp at them. The four position outputs feed the pixel generator's drawable-region window compare.

## Interface
Parameters:
- `H_DISP`, 640: active display width, pixels
- `V_DISP`, 480: active display height, lines
- `H_SIZE`, 256: region width; 1..`H_DISP`
- `V_SIZE`, 128: region height; 1..`V_DISP`
- `H_UNIT`, 8: horizontal move unit, pixels; < `H_DISP`
- `V_UNIT`, 16: vertical move unit, lines; < `V_DISP`

Ports (HW = $clog2(`H_DISP`), VW = $clog2(`V_DISP`)):
- `clk`  in  1  system pixel clock
- `reset`  in  1  synchronous, active-high; returns region to centre
- `offsetFlag`  in  4  move requests {Right, Left, Down, Up}; level inputs, rising edge is the request
- `offsetStep`  in  4  units per move, 0..15; sampled when a move starts
- `frameTick`  in  1  one-cycle pulse at start of vertical blank
- `posHorStart`, `posHorEnd`  out  HW  region horizontal bounds, inclusive
- `posVerStart`, `posVerEnd`  out  VW  region vertical bounds, inclusive
- `wrapH`, `wrapV`  out  1  region straddles right or bottom edge (End < Start)
- `busy`  out  1  high while in PEND or STEP
- `moveDone`  out  1  one-cycle pulse when a move completes

## Operation
- Edge detect: `offsetFlag` is registered once. A rising bit sets the matching bit of the 4-bit `pending` register. Bits stay set until consumed.
- Per-axis resolve: if both Left and Right are pending, both are cleared and the axis does not move. Up and Down resolve the same way.
- FSM states are IDLE, PEND, STEP and DONE:
  - IDLE → PEND when any `pending` bit is set after resolve.
  - PEND → STEP on `frameTick`. On this transition, `pending` is copied to the active direction register, `pending` is cleared, and `offsetStep` is loaded into the step counter.
  - PEND → IDLE on `frameTick` if the copied step value is 0. No move occurs and no pulse is issued.
  - STEP: each cycle, every active axis moves one unit and the counter decrements. The state exits to DONE when the counter reaches 1.
  - DONE asserts `moveDone` for one cycle. It goes to PEND if new requests are pending, otherwise to IDLE.
- Requests arriving during PEND, STEP or DONE set `pending` and are applied on the next `frameTick` after the current move. They never alter a move in progress.
- One unit, wrap mode, horizontal (vertical is analogous):
  - Right: S' = S + `H_UNIT`; if S' ≥ `H_DISP`, subtract `H_DISP`.
  - Left: if S < `H_UNIT`, S' = S + `H_DISP` − `H_UNIT`; otherwise S' = S − `H_UNIT`.
- End is always derived from Start: E = S + `H_SIZE` − 1; if E ≥ `H_DISP`, subtract `H_DISP`. Start and End are updated in the same cycle.
- Arithmetic is done at HW+1 bits (VW+1 vertically) to avoid overflow.

## Timing
- Reset values: `posHorStart` = (`H_DISP`−`H_SIZE`)/2, `posHorEnd` = Start + `H_SIZE` − 1, and the same for vertical. With defaults this gives 192/447 and 176/303.
  - All other outputs reset to 0. FSM resets to IDLE; `pending` and the edge-detect register are cleared.
- Reset mid-operation has priority in any state: outputs return to centre on the next edge and the move is abandoned.
- Latency:
  - Request edge → `pending` set: 2 cycles.
  - `frameTick` → first position update: 1 cycle.
  - Move of N units: positions settle N cycles after the STEP entry edge. `moveDone` is high in the cycle after the last update.
- Outputs are registered and glitch-free. Positions never change outside STEP.

## Configuration
- `REGION_MOVER_CLAMP_EN` defined: edges saturate instead of wrapping.
  - Left/Up: Start = max(S − unit, 0).
  - Right/Down: Start = min(S + unit, DISP − SIZE).
  - `wrapH` and `wrapV` are tied to 0.
- Undefined: wrap-around as specified in Operation.

## Structure
- Package `region_mover_pkg`:
  - default display and unit constants
  - direction bit indices (UP=0, DOWN=1, LEFT=2, RIGHT=3)
  - FSM state typedef
- Sub-module `axis_stepper`, parametrised by DISP, SIZE and UNIT. It takes the current Start plus inc/dec, produces next Start and End, and contains the wrap/clamp logic. It is instantiated once per axis.

## Test plan
- Reset → H 192/447, V 176/303; `busy`=0, `wrapH`=`wrapV`=0.
- Right edge, `offsetStep`=1, then `frameTick` → H 200/455 one cycle later; `moveDone` pulse on the next cycle.
- Up edge, `offsetStep`=12, `frameTick` → after 12 STEP cycles V 464/111, `wrapV`=1.
  - With `REGION_MOVER_CLAMP_EN`: V 0/127, `wrapV`=0.
- Left and Right rising in the same cycle, then `frameTick` → no position change, `busy` returns to 0, no `moveDone`.
- Down edge raised during a 5-unit Right move → H changes only during the current move; V +16 applied only after the next `frameTick`.
- `reset` asserted in the third STEP cycle → next cycle H 192/447, V 176/303, `busy`=0, `pending` cleared.
